fifordy1ck_prm: RTL
===================

# fifordy1ck_prm

Single-clock, parametrised ready/get FIFO; successor to the fixed 32-bit/128-entry ready FIFO. Adds configurable data width, depth and request threshold, synchronous flush, a registered free-space request flag, and optional sticky error reporting. Sits between a word producer (bus or DMA write side) and the Keccak absorb datapath, which pulls words with a get/valid handshake.

## Interface
- DW, 32, data width in bits (1..512)
- AW, 7, address width; depth = 2^AW entries (AW 2..12)
- REQTHR, 16, minimum free entries for `reqen` = 1 (1..2^AW)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- fifowr  in  1  write strobe
- fifodi  in  DW  write data
- fifoget  in  1  read request
- fifordy  out  1  at least one entry stored
- fifodout  out  DW  read data, valid when `fifovld` = 1
- fifovld  out  1  read data valid, one cycle after an accepted get
- flush  in  1  synchronous clear of FIFO contents
- reqen  out  1  free entries >= REQTHR
- fifowrerr  out  1  write attempted while full
- fiforderr  out  1  get attempted while not ready
- fifofull  out  1  level = 2^AW
- fifolen  out  AW+1  current level, 0..2^AW
- fifowa  out  AW  current write address

## Operation
- Storage: 2^AW x DW array; write pointer `wp` and read pointer `rp`, each AW bits, wrap mod 2^AW; level counter `fifolen` (AW+1 bits).
- Write accepted iff `fifowr` = 1, `fifofull` = 0, `flush` = 0: `fifodi` stored at `wp`, `wp` += 1.
- Get accepted iff `fifoget` = 1, `fifordy` = 0 is false, `flush` = 0: entry at `rp` registered to `fifodout`, `rp` += 1, `fifovld` = 1 next cycle.
- Full/empty are evaluated on the level at the start of the cycle: write while full is dropped even with a simultaneous accepted get; get while empty is rejected even with a simultaneous accepted write.
- Level: +1 for write only, -1 for get only, unchanged for both or neither.
- `fifordy` = (`fifolen` != 0); `fifofull` = (`fifolen` == 2^AW); `reqen` = ((2^AW - `fifolen`) >= REQTHR); `fifowa` = `wp`. All derive from registered state.
- Errors (default, pulse mode): `fifowrerr` pulses one cycle after a dropped write; `fiforderr` pulses one cycle after a rejected get.
- Flush: clears `wp`, `rp`, `fifolen` and `fifovld`; `fifowr` and `fifoget` in a flush cycle are ignored and raise no error. Array contents are not cleared. `fifodout` holds its last value.
- Priority: reset > flush > write/get.
- Reset values: `fifordy` 0, `fifodout` 0, `fifovld` 0, `fifowrerr` 0, `fiforderr` 0, `fifofull` 0, `fifolen` 0, `fifowa` 0, `reqen` 1.

## Timing
- Write-to-ready: write in cycle N into an empty FIFO gives `fifordy` = 1 in cycle N+1.
- Get latency: get in cycle N gives `fifovld` = 1 and `fifodout` in cycle N+1. Back-to-back gets give one word per cycle.
- `fifolen`, `fifofull`, `reqen`, `fifowa` update in the cycle after the causing event.
- Flush in cycle N gives `fifolen` = 0, `fifordy` = 0, `fifovld` = 0 in cycle N+1.
- Full throughput: simultaneous write and get every cycle, with no bubbles, at any level 1..2^AW-1.

## Configuration
- `FIFORDY_STICKYERR_EN` defined: `fifowrerr` and `fiforderr` set on the event and stay high until `flush` or reset. Flush clears them in cycle N+1.
- Not defined: both flags are single-cycle pulses, as described under Operation.

## Test plan
- Reset, then 10 writes of i*10 (i = 0..9), then 10 gets -> `fifodout` = 0,10,...,90 each one cycle after its get; 10 `fifovld` pulses; no errors; `fifolen` ends at 0.
- Fill with AW=2 (4 entries), then write 0xDEAD -> `fifofull` = 1, `fifolen` = 4, `fifowrerr` pulses, 0xDEAD is never read back.
- Get on empty with a simultaneous write of 0x5 -> `fiforderr` pulses, no `fifovld`, `fifolen` = 1, next get returns 0x5.
- AW=4, REQTHR=4: write 12 words -> `reqen` = 1 through level 12; 13th write -> `reqen` = 0 the next cycle.
- Wrap-around: with AW=2, run 20 cycles of simultaneous write/get at level 2 -> data is in order, `fifowa` wraps 3 to 0, `fifolen` stays 2.
- Flush at level 5 with concurrent write and get -> `fifolen` = 0 and `fifovld` = 0 next cycle, no error. With `FIFORDY_STICKYERR_EN`, a prior `fifowrerr` clears.

Source files
------------

// File: rtl/fifordy1ck_prm_if.sv
// ============================================================================
//  Module   : fifordy1ck_prm_if
//  Purpose  : Handshake bundle for the parametrised ready/get FIFO.
//             The master side is the producer/consumer pair, the slave side
//             is the FIFO itself.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fifordy1ck_prm_if #(
    parameter int DW = 32,
    parameter int AW = 7
) ();
    // producer / consumer driven
    logic          fifowr;
    logic [DW-1:0] fifodi;
    logic          fifoget;
    logic          flush;
    // FIFO driven
    logic          fifordy;
    logic [DW-1:0] fifodout;
    logic          fifovld;
    logic          reqen;
    logic          fifowrerr;
    logic          fiforderr;
    logic          fifofull;
    logic [AW:0]   fifolen;
    logic [AW-1:0] fifowa;

    modport master (
        output fifowr, fifodi, fifoget, flush,
        input  fifordy, fifodout, fifovld, reqen,
        input  fifowrerr, fiforderr, fifofull, fifolen, fifowa
    );

    modport slave (
        input  fifowr, fifodi, fifoget, flush,
        output fifordy, fifodout, fifovld, reqen,
        output fifowrerr, fiforderr, fifofull, fifolen, fifowa
    );
endinterface

`default_nettype wire

// File: rtl/fifordy1ck_prm.sv
// ============================================================================
//  Module   : fifordy1ck_prm
//  Purpose  : Single-clock parametrised ready/get FIFO with synchronous flush,
//             registered free-space request flag and write/get error flags.
//             Optional macro FIFORDY_STICKYERR_EN makes the error flags sticky
//             until flush or reset; otherwise they are one-cycle pulses.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifordy1ck_prm #(
    parameter int DW     = 32,
    parameter int AW     = 7,
    parameter int REQTHR = 16
) (
    input  logic           clk,
    input  logic           rstn,
    fifordy1ck_prm_if.slave bus
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_REQTHR = (AW+1)'(REQTHR);
    localparam logic [AW:0] C_ONE    = (AW+1)'(1);

    // storage and registered state
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_len;
    logic [DW-1:0] r_dout;
    logic          r_vld;
    logic          r_wrerr;
    logic          r_rderr;
    logic          r_reqen;

    // combinational qualifiers, all based on the level at the start of the cycle
    logic          w_full;
    logic          w_rdy;
    logic          w_wacc;
    logic          w_gacc;
    logic          w_wdrop;
    logic          w_grej;
    logic [AW:0]   w_len_nxt;
    logic [AW:0]   w_free_nxt;

    assign w_full  = (r_len == C_DEPTH);
    assign w_rdy   = (r_len != '0);

    // flush suppresses both accepts and errors in the same cycle
    assign w_wacc  = bus.fifowr  &  ~w_full & ~bus.flush;
    assign w_gacc  = bus.fifoget &   w_rdy  & ~bus.flush;
    assign w_wdrop = bus.fifowr  &   w_full & ~bus.flush;
    assign w_grej  = bus.fifoget &  ~w_rdy  & ~bus.flush;

    // next level: flush wins, otherwise +1/-1/hold depending on the accepts
    always_comb begin
        w_len_nxt = r_len;
        if (bus.flush) begin
            w_len_nxt = '0;
        end else if (w_wacc && !w_gacc) begin
            w_len_nxt = r_len + C_ONE;
        end else if (w_gacc && !w_wacc) begin
            w_len_nxt = r_len - C_ONE;
        end
    end

    assign w_free_nxt = C_DEPTH - w_len_nxt;

    // array write; contents deliberately survive flush and reset
    always_ff @(posedge clk) begin
        if (rstn && w_wacc) begin
            r_mem[r_wp] <= bus.fifodi;
        end
    end

    // pointers, level and request flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_len   <= '0;
            r_reqen <= 1'b1;
        end else begin
            if (bus.flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_wacc) begin
                    r_wp <= r_wp + 1'b1;
                end
                if (w_gacc) begin
                    r_rp <= r_rp + 1'b1;
                end
            end
            r_len   <= w_len_nxt;
            r_reqen <= (w_free_nxt >= C_REQTHR);
        end
    end

    // read data register; holds its last word when no get is accepted
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_dout <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= w_gacc;
            if (w_gacc) begin
                r_dout <= r_mem[r_rp];
            end
        end
    end

    // error flags: pulse by default, sticky until flush when the macro is set
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wrerr <= 1'b0;
            r_rderr <= 1'b0;
        end else begin
`ifdef FIFORDY_STICKYERR_EN
            if (bus.flush) begin
                r_wrerr <= 1'b0;
                r_rderr <= 1'b0;
            end else begin
                r_wrerr <= r_wrerr | w_wdrop;
                r_rderr <= r_rderr | w_grej;
            end
`else
            r_wrerr <= w_wdrop;
            r_rderr <= w_grej;
`endif
        end
    end

    assign bus.fifordy   = w_rdy;
    assign bus.fifofull  = w_full;
    assign bus.fifolen   = r_len;
    assign bus.fifowa    = r_wp;
    assign bus.reqen     = r_reqen;
    assign bus.fifodout  = r_dout;
    assign bus.fifovld   = r_vld;
    assign bus.fifowrerr = r_wrerr;
    assign bus.fiforderr = r_rderr;

endmodule

`default_nettype wire
